enum3_seq: RTL and testbench
============================

# enum3_seq

Sequencer that walks the 5-bit `state_t` enumeration (AA, BB, CC0–CC4, DD, EE0–EE1, FF, GG0–GG1, HH0–HH3, II0–II3) in declaration order and presents the current member with a valid/ready handshake. It sits directly upstream of the enum-consuming stage, supplying one legal `state_t` code per accepted transfer. It also supports a direct jump to any member and counts full-sequence wraps.

## Interface
Parameters:
- `BVAL`, 2: encoding of BB; must stay 2 or 3 so the CC range starting at 4 does not collide.
- `WRAP_W`, 8: width of the wrap counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: enables advancing on each accepted transfer.
- `jmp_valid` in 1: jump request, single-cycle.
- `jmp_code` in 5: target encoding for the jump.
- `out_valid` out 1: `out_code` is presented.
- `out_ready` in 1: downstream accepts.
- `out_code` out 5: current member encoding (`state_t`).
- `out_ord` out 5: ordinal of the current member, 0..20.
- `wrap_cnt` out `WRAP_W`: number of II3→AA wraps, modulo 2^`WRAP_W`.
- `jmp_err` out 1: one-cycle pulse when `jmp_code` is not a member.
- `dir` in 1: direction, 0 = forward, 1 = reverse. Present only with `ENUM3_SEQ_DIR_EN`.

## Operation
- Legal set and ordinals: AA=0/0, BB=`BVAL`/1, CC0..CC4=4..8/2..6, DD=9/7, EE0..EE1=11..12/8..9, FF=13/10, GG0..GG1=14..15/11..12, HH0..HH3=20..23/13..16, II0..II3=24..27/17..20.
- Codes 1, 3 (or 2 when `BVAL`=3), 10, 16–19, and 28–31 are never emitted.
- A transfer happens on a clock edge with `out_valid && out_ready`.
- FSM states:
  - IDLE: `out_valid`=0.
  - PRESENT: `out_valid`=1.
- Transitions:
  - IDLE→PRESENT: on `run`=1. `out_code` keeps its current value.
  - PRESENT, transfer, `run`=1: step to the successor member and stay in PRESENT.
  - PRESENT, transfer, `run`=0: go to IDLE; code unchanged.
  - PRESENT, no transfer: hold `out_code`, `out_ord` and `out_valid` stable. This is mandatory; the handshake must not drop.
- Wrap:
  - Forward successor of II3 is AA; `wrap_cnt` increments.
  - Reverse successor of AA is II3; `wrap_cnt` decrements.
  - The counter rolls over modulo 2^`WRAP_W`.
- Jump:
  - `jmp_valid` with a legal code loads it in any state; FSM state is unchanged.
  - A jump beats a simultaneous transfer-advance. The transfer still completes with the old code, and the advance is discarded.
  - An illegal code leaves all state unchanged and pulses `jmp_err` for exactly one cycle.
  - A jump never changes `wrap_cnt`.
- Arithmetic: `out_ord` is derived from `out_code` combinationally. The successor uses a lookup, never raw +1.

## Timing
- Reset values:
  - FSM state: IDLE.
  - `out_valid`=0.
  - `out_code`=AA (0), `out_ord`=0.
  - `wrap_cnt`=0.
  - `jmp_err`=0.
- Reset is honoured mid-transfer: all registers clear asynchronously, and `out_valid` drops in the same cycle `rst_n` falls.
- Latency:
  - `run` to `out_valid`: 1 cycle.
  - Transfer to next code: 1 cycle, giving back-to-back throughput of one member per cycle.
  - Jump to new `out_code`: 1 cycle.
  - Illegal jump to `jmp_err`: 1 cycle.
- Every output is registered except `out_ord`, which is combinational from `out_code`.

## Configuration
- `ENUM3_SEQ_DIR_EN` defined:
  - The `dir` port exists; `dir`=1 selects the predecessor member on each advance.
  - `dir` is sampled at the transfer edge.
- Not defined:
  - No `dir` port; the sequencer is forward-only.
  - Wrap-counter decrement logic is absent.

## Structure
- Package `enum3_pkg` holds:
  - `state_t` (enum logic [4:0] with the ranges above, BB bound to `BVAL`).
  - Constant `ENUM3_NUM_MEMBERS`=21.
  - Functions `enum3_is_legal`, `enum3_ord`, `enum3_next`, `enum3_prev`.
- Sub-module `enum3_succ`: combinational, takes `code` and `dir`, returns the next code, an `is_wrap` flag and `is_legal`. `enum3_seq` instantiates it once for the advance path and once for jump checking.
- The FSM and registers live in `enum3_seq`.

## Test plan
- Reset, then `run`=1 with `out_ready`=1 for 21 cycles: codes 0,2,4,5,6,7,8,9,11,12,13,14,15,20,21,22,23,24,25,26,27, then 0 again; `wrap_cnt`=1.
- Backpressure: at CC2 (6), hold `out_ready`=0 for 5 cycles → `out_code`=6 and `out_valid`=1 stay stable; the next transfer yields 7.
- Jump: `jmp_code`=20 while transferring at DD → the transfer completes with 9, next `out_code`=20 with `out_ord`=13; `jmp_code`=17 → `jmp_err` pulses once and the code is unchanged.
- Wrap rollover: 256 full passes → `wrap_cnt` returns to 0. With `ENUM3_SEQ_DIR_EN`, `dir`=1 at AA → next code 27 and `wrap_cnt`=255.
- Async reset: drop `rst_n` mid-stream at HH1 → `out_valid`=0 immediately; after release, `out_code`=0, FSM in IDLE.
- `run`=0 during a transfer at FF → enters IDLE with code 13; `run`=1 → re-presents 13 one cycle later.

Source files
------------

// File: rtl/enum3_pkg.sv
// Member encoding, ordinal/successor helpers and FSM type for the enum3 sequencer.
// BB's code is a function argument so the sequencer's BVAL parameter can move it (2 or 3).
package enum3_pkg;

   localparam logic [4:0]  ENUM3_BVAL        = 5'd2;
   localparam int unsigned ENUM3_NUM_MEMBERS = 21;

   typedef enum logic [4:0] {
      AA  = 5'd0,  BB  = ENUM3_BVAL,
      CC0 = 5'd4,  CC1 = 5'd5,  CC2 = 5'd6,  CC3 = 5'd7,  CC4 = 5'd8,
      DD  = 5'd9,  EE0 = 5'd11, EE1 = 5'd12, FF  = 5'd13,
      GG0 = 5'd14, GG1 = 5'd15,
      HH0 = 5'd20, HH1 = 5'd21, HH2 = 5'd22, HH3 = 5'd23,
      II0 = 5'd24, II1 = 5'd25, II2 = 5'd26, II3 = 5'd27
   } state_t;

   typedef enum logic [0:0] {StIdle, StPresent} fsm_t;

   function automatic logic enum3_is_legal(input logic [4:0] code, input logic [4:0] bval);
      return (code == AA) || (code == bval) ||
             (code inside {[5'd4:5'd9], [5'd11:5'd15], [5'd20:5'd27]});
   endfunction

   function automatic logic [4:0] enum3_ord(input logic [4:0] code, input logic [4:0] bval);
      logic [4:0] ord;
      ord = 5'd0;
      if (code == bval)                          ord = 5'd1;
      else if (code inside {[5'd4:5'd9]})        ord = code - 5'd2;
      else if (code inside {[5'd11:5'd15]})      ord = code - 5'd3;
      else if (code inside {[5'd20:5'd27]})      ord = code - 5'd7;
      return ord;
   endfunction

   function automatic logic [4:0] enum3_next(input logic [4:0] code, input logic [4:0] bval);
      logic [4:0] n;
      n = 5'd0;
      if (code == AA)        n = bval;
      else if (code == bval) n = 5'd4;
      else begin
         case (code)
            5'd4:  n = 5'd5;   5'd5:  n = 5'd6;   5'd6:  n = 5'd7;   5'd7:  n = 5'd8;
            5'd8:  n = 5'd9;   5'd9:  n = 5'd11;  5'd11: n = 5'd12;  5'd12: n = 5'd13;
            5'd13: n = 5'd14;  5'd14: n = 5'd15;  5'd15: n = 5'd20;  5'd20: n = 5'd21;
            5'd21: n = 5'd22;  5'd22: n = 5'd23;  5'd23: n = 5'd24;  5'd24: n = 5'd25;
            5'd25: n = 5'd26;  5'd26: n = 5'd27;  5'd27: n = 5'd0;
            default: n = 5'd0;
         endcase
      end
      return n;
   endfunction

   function automatic logic [4:0] enum3_prev(input logic [4:0] code, input logic [4:0] bval);
      logic [4:0] p;
      p = 5'd0;
      if (code == AA)        p = 5'd27;
      else if (code == bval) p = 5'd0;
      else begin
         case (code)
            5'd4:  p = bval;   5'd5:  p = 5'd4;   5'd6:  p = 5'd5;   5'd7:  p = 5'd6;
            5'd8:  p = 5'd7;   5'd9:  p = 5'd8;   5'd11: p = 5'd9;   5'd12: p = 5'd11;
            5'd13: p = 5'd12;  5'd14: p = 5'd13;  5'd15: p = 5'd14;  5'd20: p = 5'd15;
            5'd21: p = 5'd20;  5'd22: p = 5'd21;  5'd23: p = 5'd22;  5'd24: p = 5'd23;
            5'd25: p = 5'd24;  5'd26: p = 5'd25;  5'd27: p = 5'd26;
            default: p = 5'd0;
         endcase
      end
      return p;
   endfunction

endpackage

// File: rtl/enum3_succ.sv
// Combinational successor/predecessor lookup over the enum3 member table.
module enum3_succ
   import enum3_pkg::*;
#(
   parameter int unsigned BVAL = 2
) (
   input  logic [4:0] i_code,
   input  logic       i_dir,
   output logic [4:0] o_next,
   output logic       o_is_wrap,
   output logic       o_is_legal
);

   localparam logic [4:0] BbCode = 5'(BVAL);

   always_comb begin
      o_is_legal = enum3_is_legal(i_code, BbCode);
      o_next     = i_dir ? enum3_prev(i_code, BbCode) : enum3_next(i_code, BbCode);
      o_is_wrap  = i_dir ? (i_code == AA) : (i_code == II3);
   end

endmodule

// File: rtl/enum3_seq.sv
// Valid/ready sequencer over the enum3 members with jump and wrap counting.
// Define ENUM3_SEQ_DIR_EN to add the dir port (reverse stepping, wrap-counter decrement).
module enum3_seq
   import enum3_pkg::*;
#(
   parameter int unsigned BVAL   = 2,
   parameter int unsigned WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              jmp_valid,
   input  logic [4:0]        jmp_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_code,
   output logic [4:0]        out_ord,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              jmp_err
`ifdef ENUM3_SEQ_DIR_EN
   ,
   input  logic              dir
`endif
);

   localparam logic [4:0] BbCode = 5'(BVAL);

   fsm_t              r_state, w_state_d;
   logic [4:0]        r_code, w_code_d;
   logic [WRAP_W-1:0] r_wrap, w_wrap_d;
   logic              r_jmp_err, w_jmp_err_d;

   logic       w_dir, w_xfer;
   logic [4:0] w_adv_next, w_jmp_next;
   logic       w_adv_wrap, w_adv_legal, w_jmp_wrap, w_jmp_legal;
   logic [5:0] w_jmp_unused;

`ifdef ENUM3_SEQ_DIR_EN
   assign w_dir = dir;
`else
   assign w_dir = 1'b0;
`endif

   enum3_succ #(.BVAL(BVAL)) u_adv (
      .i_code     (r_code),
      .i_dir      (w_dir),
      .o_next     (w_adv_next),
      .o_is_wrap  (w_adv_wrap),
      .o_is_legal (w_adv_legal)
   );

   // Only the legality flag matters on the jump path.
   enum3_succ #(.BVAL(BVAL)) u_jmp (
      .i_code     (jmp_code),
      .i_dir      (1'b0),
      .o_next     (w_jmp_next),
      .o_is_wrap  (w_jmp_wrap),
      .o_is_legal (w_jmp_legal)
   );
   assign w_jmp_unused = {w_jmp_next, w_jmp_wrap};

   assign w_xfer = (r_state == StPresent) && out_ready;

   always_comb begin
      w_state_d   = r_state;
      w_code_d    = r_code;
      w_wrap_d    = r_wrap;
      w_jmp_err_d = 1'b0;
      case (r_state)
         StIdle: begin
            if (run) w_state_d = StPresent;
         end
         StPresent: begin
            if (w_xfer) begin
               if (!run) begin
                  w_state_d = StIdle;
               end else if (w_adv_legal) begin
                  w_code_d = w_adv_next;
                  if (w_adv_wrap) begin
`ifdef ENUM3_SEQ_DIR_EN
                     w_wrap_d = w_dir ? r_wrap - WRAP_W'(1) : r_wrap + WRAP_W'(1);
`else
                     w_wrap_d = r_wrap + WRAP_W'(1);
`endif
                  end
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
      // A legal jump overrides any advance, including its wrap count.
      if (jmp_valid) begin
         if (w_jmp_legal) begin
            w_code_d = jmp_code;
            w_wrap_d = r_wrap;
         end else begin
            w_jmp_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_code    <= 5'd0;
         r_wrap    <= '0;
         r_jmp_err <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_code    <= w_code_d;
         r_wrap    <= w_wrap_d;
         r_jmp_err <= w_jmp_err_d;
      end
   end

   assign out_valid = (r_state == StPresent);
   assign out_code  = r_code;
   assign out_ord   = enum3_ord(r_code, BbCode);
   assign wrap_cnt  = r_wrap;
   assign jmp_err   = r_jmp_err;

endmodule

// File: tb/tb_enum3_seq.sv
// Self-checking bench for enum3_seq: member-table model checked every cycle plus literal pins.
module tb_enum3_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       jmp_valid = 1'b0;
   logic [4:0] jmp_code = 5'd0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [4:0] out_code, out_ord;
   logic [7:0] wrap_cnt;
   logic       jmp_err;
`ifdef ENUM3_SEQ_DIR_EN
   logic dir = 1'b0;
   wire  m_dir = dir;
`else
   wire  m_dir = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   enum3_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .jmp_valid (jmp_valid),
      .jmp_code  (jmp_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_ord   (out_ord),
      .wrap_cnt  (wrap_cnt),
      .jmp_err   (jmp_err)
`ifdef ENUM3_SEQ_DIR_EN
      ,
      .dir       (dir)
`endif
   );

   // Members in declaration order; the index is the ordinal.
   int seq_tab [21] = '{0, 2, 4, 5, 6, 7, 8, 9, 11, 12, 13, 14, 15, 20, 21, 22, 23, 24, 25, 26, 27};

   function automatic int find_idx(input int code);
      for (int i = 0; i < 21; i++) if (seq_tab[i] == code) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   bit         m_valid;
   int         m_idx;
   logic [7:0] m_wrap;
   bit         m_err;

   always @(posedge clk or negedge rst_n) begin : mdl
      int   nidx, jpos;
      bit   nvalid;
      logic [7:0] nwrap;
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_idx   <= 0;
         m_wrap  <= 8'd0;
         m_err   <= 1'b0;
      end else begin
         nidx   = m_idx;
         nvalid = m_valid;
         nwrap  = m_wrap;
         jpos   = find_idx(int'(jmp_code));
         if (!m_valid) begin
            if (run) nvalid = 1'b1;
         end else if (out_ready) begin
            if (!run) nvalid = 1'b0;
            else if (m_dir) begin
               nidx = (m_idx == 0) ? 20 : m_idx - 1;
               if (m_idx == 0) nwrap = m_wrap - 8'd1;
            end else begin
               nidx = (m_idx + 1) % 21;
               if (m_idx == 20) nwrap = m_wrap + 8'd1;
            end
         end
         m_err <= 1'b0;
         if (jmp_valid) begin
            if (jpos >= 0) begin
               nidx  = jpos;
               nwrap = m_wrap;
            end else begin
               m_err <= 1'b1;
            end
         end
         m_valid <= nvalid;
         m_idx   <= nidx;
         m_wrap  <= nwrap;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", int'(out_valid), int'(m_valid));
         chk("out_code", int'(out_code), seq_tab[m_idx]);
         chk("out_ord", int'(out_ord), m_idx);
         chk("wrap_cnt", int'(wrap_cnt), int'(m_wrap));
         chk("jmp_err", int'(jmp_err), int'(m_err));
      end
   end

   int exp_pass [22] = '{0, 2, 4, 5, 6, 7, 8, 9, 11, 12, 13, 14, 15, 20, 21, 22, 23, 24, 25, 26,
                         27, 0};

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_code", int'(out_code), 0);
      chk("rst_ord", int'(out_ord), 0);
      chk("rst_wrap", int'(wrap_cnt), 0);
      chk("rst_err", int'(jmp_err), 0);

      // Full forward pass
      run = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         chk("pass_code", int'(out_code), exp_pass[k]);
      end
      chk("pass_wrap", int'(wrap_cnt), 1);

      // Backpressure at CC2
      repeat (4) @(negedge clk);
      chk("bp_at_cc2", int'(out_code), 6);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_code", int'(out_code), 6);
         chk("bp_hold_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", int'(out_code), 7);

      // Jump during a transfer at DD
      repeat (2) @(negedge clk);
      chk("at_dd", int'(out_code), 9);
      jmp_valid = 1'b1;
      jmp_code  = 5'd20;
      @(negedge clk);
      jmp_valid = 1'b0;
      chk("jmp_code", int'(out_code), 20);
      chk("jmp_ord", int'(out_ord), 13);
      chk("jmp_wrap", int'(wrap_cnt), 1);

      // Illegal jump
      out_ready = 1'b0;
      jmp_valid = 1'b1;
      jmp_code  = 5'd17;
      @(negedge clk);
      jmp_valid = 1'b0;
      chk("bad_jmp_err", int'(jmp_err), 1);
      chk("bad_jmp_code", int'(out_code), 20);
      @(negedge clk);
      chk("bad_jmp_err_clr", int'(jmp_err), 0);

      // run=0 during a transfer at FF
      jmp_valid = 1'b1;
      jmp_code  = 5'd13;
      @(negedge clk);
      jmp_valid = 1'b0;
      chk("at_ff", int'(out_code), 13);
      out_ready = 1'b1;
      run = 1'b0;
      @(negedge clk);
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_code", int'(out_code), 13);
      run = 1'b1;
      @(negedge clk);
      chk("repres_valid", int'(out_valid), 1);
      chk("repres_code", int'(out_code), 13);

      // Wrap counter rollover back to 0
      repeat (11 + 254 * 21) @(negedge clk);
      chk("roll_code", int'(out_code), 0);
      chk("roll_wrap", int'(wrap_cnt), 0);

`ifdef ENUM3_SEQ_DIR_EN
      dir = 1'b1;
      @(negedge clk);
      dir = 1'b0;
      chk("rev_code", int'(out_code), 27);
      chk("rev_wrap", int'(wrap_cnt), 255);
`endif

      // Async reset mid-stream at HH1
      jmp_valid = 1'b1;
      jmp_code  = 5'd21;
      @(negedge clk);
      jmp_valid = 1'b0;
      chk("at_hh1", int'(out_code), 21);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_code", int'(out_code), 0);
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", int'(out_valid), 0);
      chk("post_rst_code", int'(out_code), 0);
      @(negedge clk);
      chk("post_rst_idle", int'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
